// File: rtl/regfile_scan_reader.sv
// -----------------------------------------------------------------------------
// regfile_scan_reader
//
// Reader-side companion to the 32x32 register file. It owns one read-address
// port of the file, walks an inclusive register range (wrapping through the
// top index back to 0 when first > last) and streams each value out over a
// valid/ready handshake. Consumers can sample any register window without
// dedicated tap ports. With AUTO_PERIOD > 0 the last programmed range is
// rescanned automatically AUTO_PERIOD idle cycles after each completed scan.
//
// Ports
//   clock         system clock, all state on the rising edge
//   ctrl_reset_n  asynchronous active-low reset
//   start         one-cycle scan request, ignored while busy
//   abort         terminate the current scan (no done pulse)
//   first_reg     first register index, sampled on an accepted start
//   last_reg      last register index, sampled on an accepted start
//   ctrl_readReg  read address driven to the register file
//   data_readReg  combinational read data for ctrl_readReg
//   out_valid     out_data/out_index/out_last hold a word
//   out_ready     consumer accepts the word when out_valid & out_ready
//   out_data      register value
//   out_index     register index of out_data
//   out_last      word is the final one of the range
//   busy          scan in progress
//   done          one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module regfile_scan_reader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int AUTO_PERIOD = 0
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_reg,
   input  logic [ADDR_WIDTH-1:0] last_reg,
   output logic [ADDR_WIDTH-1:0] ctrl_readReg,
   input  logic [DATA_WIDTH-1:0] data_readReg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   // Period counter only needs to reach AUTO_PERIOD, where it saturates.
   localparam int                    PERIOD_W   = (AUTO_PERIOD > 0) ? $clog2(AUTO_PERIOD + 1) : 1;
   localparam logic [PERIOD_W-1:0]   PERIOD_MAX = PERIOD_W'(AUTO_PERIOD);
   localparam logic [PERIOD_W-1:0]   PERIOD_ONE = PERIOD_W'(1);
   localparam logic                  AUTO_EN    = (AUTO_PERIOD > 0);
   // Remaining-word counter is one bit wider so a full 32-word range fits.
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH:0]     remaining_q;
   logic [ADDR_WIDTH-1:0]   first_q;
   logic [ADDR_WIDTH-1:0]   last_q;
   logic [PERIOD_W-1:0]     period_q;
   logic                    armed_q;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [ADDR_WIDTH-1:0]   out_index_q;
   logic                    out_last_q;
   logic                    done_q;

   logic                    auto_fire_d;
   logic                    launch_d;
   logic [ADDR_WIDTH-1:0]   scan_first_d;
   logic [ADDR_WIDTH-1:0]   scan_last_d;
   logic [ADDR_WIDTH-1:0]   span_d;
   logic [ADDR_WIDTH:0]     range_len_d;
   logic                    load_d;

   always_comb begin
      // NOTE: every always_comb output is assigned on every path (here
      // unconditionally), so no latch can be inferred.
      auto_fire_d  = AUTO_EN && armed_q && (period_q == PERIOD_MAX);
      launch_d     = start || auto_fire_d;
      // An explicit start wins over the auto trigger and brings new bounds.
      scan_first_d = start ? first_reg : first_q;
      scan_last_d  = start ? last_reg  : last_q;
      // Modular difference gives the wrapped range length for first > last.
      span_d       = scan_last_d - scan_first_d;
      range_len_d  = {1'b0, span_d} + CNT_ONE;
      // The output register may be refilled when empty or being drained.
      load_d       = !out_valid_q || out_ready;
   end

   // NOTE: all state, including the data path, is reset because every
   // output must read 0 during reset; the block holds no memory array.
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         first_q     <= '0;
         last_q      <= '0;
         period_q    <= '0;
         armed_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update in this
         // block based on the pre-edge values, independent of statement order.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch_d) begin
                  first_q     <= scan_first_d;
                  last_q      <= scan_last_d;
                  addr_q      <= scan_first_d;
                  remaining_q <= range_len_d;
                  period_q    <= '0;
                  state_q     <= READ;
                  if (start) begin
                     armed_q <= 1'b1;
                  end
               end else if (AUTO_EN && armed_q && (period_q != PERIOD_MAX)) begin
                  period_q <= period_q + PERIOD_ONE;
               end
            end

            READ: begin
               if (abort) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= IDLE;
               end else if (load_d) begin
                  out_data_q  <= data_readReg;
                  out_index_q <= addr_q;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (remaining_q == CNT_ONE);
                  addr_q      <= addr_q + ADDR_ONE;
                  remaining_q <= remaining_q - CNT_ONE;
                  if (remaining_q == CNT_ONE) begin
                     state_q <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (abort) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= IDLE;
               end else if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  done_q      <= 1'b1;
                  period_q    <= '0;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ctrl_readReg = addr_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_index    = out_index_q;
   assign out_last     = out_last_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_scan_reader. Two instances share one register-file
// model: dut (auto-rescan disabled) and dut_a (AUTO_PERIOD = 4). Expected
// words for dut are pushed to a queue when a scan is requested and popped by
// a monitor on each handshake; dut_a is checked with directed cycle steps.
// -----------------------------------------------------------------------------
module tb_regfile_scan_reader;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  idx;
      logic        last;
   } word_t;

   logic        clock;
   logic        ctrl_reset_n;

   logic        start, abort, out_ready;
   logic [4:0]  first_reg, last_reg, ctrl_readReg, out_index;
   logic [31:0] data_readReg, out_data;
   logic        out_valid, out_last, busy, done;

   logic        a_start, a_abort, a_out_ready;
   logic [4:0]  a_first_reg, a_last_reg, a_ctrl_readReg, a_out_index;
   logic [31:0] a_data_readReg, a_out_data;
   logic        a_out_valid, a_out_last, a_busy, a_done;

   logic [31:0] rf [32];
   word_t       sb [$];

   int          checks   = 0;
   int          failures = 0;
   logic        chk_stall = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_data;
   logic [4:0]  prev_addr;

   regfile_scan_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .AUTO_PERIOD(0)) dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .start        (start),
      .abort        (abort),
      .first_reg    (first_reg),
      .last_reg     (last_reg),
      .ctrl_readReg (ctrl_readReg),
      .data_readReg (data_readReg),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_index    (out_index),
      .out_last     (out_last),
      .busy         (busy),
      .done         (done)
   );

   regfile_scan_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .AUTO_PERIOD(4)) dut_a (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .start        (a_start),
      .abort        (a_abort),
      .first_reg    (a_first_reg),
      .last_reg     (a_last_reg),
      .ctrl_readReg (a_ctrl_readReg),
      .data_readReg (a_data_readReg),
      .out_valid    (a_out_valid),
      .out_ready    (a_out_ready),
      .out_data     (a_out_data),
      .out_index    (a_out_index),
      .out_last     (a_out_last),
      .busy         (a_busy),
      .done         (a_done)
   );

   // Register file read path: register 0 always reads as zero.
   always_comb begin
      data_readReg   = (ctrl_readReg == 5'd0) ? 32'd0 : rf[ctrl_readReg];
      a_data_readReg = (a_ctrl_readReg == 5'd0) ? 32'd0 : rf[a_ctrl_readReg];
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : rf[a];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_range(input logic [4:0] f, input logic [4:0] l);
      logic [4:0] span;
      logic [4:0] idx;
      int         n;
      span = l - f;
      n    = int'(span) + 1;
      for (int k = 0; k < n; k++) begin
         idx = f + 5'(k);
         sb.push_back('{data: rd(idx), idx: idx, last: (k == n - 1)});
      end
   endtask

   task automatic issue_start(input logic [4:0] f, input logic [4:0] l);
      first_reg = f;
      last_reg  = l;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   // Steps until done is seen; cycles counts edges after the start edge.
   task automatic wait_done(input int budget, output int cycles);
      logic got;
      got    = 1'b0;
      cycles = 0;
      while (!got && cycles < budget) begin
         step();
         cycles++;
         if (done) got = 1'b1;
      end
      check("wait_done_in_budget", 64'(got), 64'(1));
   endtask

   task automatic a_expect_scan(input logic [4:0] f, input logic [4:0] l);
      logic [4:0] span;
      logic [4:0] idx;
      int         n;
      span = l - f;
      n    = int'(span) + 1;
      for (int k = 0; k < n; k++) begin
         idx = f + 5'(k);
         step();
         check("auto_valid", 64'(a_out_valid), 64'(1));
         check("auto_index", 64'(a_out_index), 64'(idx));
         check("auto_data",  64'(a_out_data), 64'(rd(idx)));
         check("auto_last",  64'(a_out_last), 64'(k == n - 1));
      end
      step();
      check("auto_done", 64'(a_done), 64'(1));
      check("auto_busy_after_done", 64'(a_busy), 64'(0));
   endtask

   // Counts idle cycles between the done sample and busy rising again.
   task automatic a_idle_check();
      int k;
      k = 0;
      while (k < 20) begin
         step();
         if (a_busy) break;
         k++;
      end
      check("auto_idle_cycles", 64'(k), 64'(4));
   endtask

   // Scoreboard monitor: one pop per handshake, sampled away from the edge.
   always @(negedge clock) begin
      if (ctrl_reset_n) begin
         if (chk_stall && stall_prev && out_valid) begin
            check("stall_data_stable", 64'(out_data), 64'(prev_data));
            check("stall_addr_stable", 64'(ctrl_readReg), 64'(prev_addr));
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_addr  = ctrl_readReg;
         if (out_valid && out_ready) begin
            check("sb_word_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
               word_t w;
               w = sb.pop_front();
               check("sb_data",  64'(out_data),  64'(w.data));
               check("sb_index", 64'(out_index), 64'(w.idx));
               check("sb_last",  64'(out_last),  64'(w.last));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int pat [4];
      logic got;

      pat          = '{1, 0, 0, 1};
      ctrl_reset_n = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      first_reg    = '0;
      last_reg     = '0;
      out_ready    = 1'b0;
      a_start      = 1'b0;
      a_abort      = 1'b0;
      a_first_reg  = '0;
      a_last_reg   = '0;
      a_out_ready  = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;

      // Reset state.
      #2;
      check("rst_busy",      64'(busy), 64'(0));
      check("rst_valid",     64'(out_valid), 64'(0));
      check("rst_readReg",   64'(ctrl_readReg), 64'(0));
      check("rst_done",      64'(done), 64'(0));
      check("rst_data",      64'(out_data), 64'(0));
      check("rst_index",     64'(out_index), 64'(0));
      check("rst_last",      64'(out_last), 64'(0));
      @(negedge clock);
      ctrl_reset_n = 1'b1;
      step();

      // Basic 27..29 scan with cycle-exact timing.
      rf[27] = 32'h11; rf[28] = 32'h22; rf[29] = 32'h33;
      out_ready = 1'b1;
      push_range(5'd27, 5'd29);
      issue_start(5'd27, 5'd29);
      check("t1_busy_after_start", 64'(busy), 64'(1));
      check("t1_no_word_yet",      64'(out_valid), 64'(0));
      for (int k = 0; k < 3; k++) begin
         step();
         check("t1_valid", 64'(out_valid), 64'(1));
         check("t1_index", 64'(out_index), 64'(27 + k));
         check("t1_last",  64'(out_last), 64'(k == 2));
      end
      step();
      check("t1_done",       64'(done), 64'(1));
      check("t1_busy_low",   64'(busy), 64'(0));
      check("t1_valid_low",  64'(out_valid), 64'(0));
      step();
      check("t1_done_pulse", 64'(done), 64'(0));
      check("t1_sb_empty",   64'(sb.size()), 64'(0));
      check("auto_disarmed", 64'(a_busy), 64'(0));

      // Reset asserted mid-scan.
      push_range(5'd27, 5'd29);
      issue_start(5'd27, 5'd29);
      step();
      step();
      #2;
      ctrl_reset_n = 1'b0;
      #1;
      check("mrst_valid",   64'(out_valid), 64'(0));
      check("mrst_data",    64'(out_data), 64'(0));
      check("mrst_index",   64'(out_index), 64'(0));
      check("mrst_last",    64'(out_last), 64'(0));
      check("mrst_busy",    64'(busy), 64'(0));
      check("mrst_done",    64'(done), 64'(0));
      check("mrst_readReg", 64'(ctrl_readReg), 64'(0));
      check("mrst_words_left", 64'(sb.size()), 64'(2));
      sb.delete();
      step();
      step();
      check("mrst_no_done", 64'(done), 64'(0));
      @(negedge clock);
      ctrl_reset_n = 1'b1;
      step();
      check("mrst_no_done_after", 64'(done), 64'(0));
      check("mrst_idle_after",    64'(busy), 64'(0));

      // Backpressure, ready pattern 1,0,0,1 repeating.
      rf[1] = 32'hA1; rf[2] = 32'hA2; rf[3] = 32'hA3; rf[4] = 32'hA4;
      push_range(5'd1, 5'd4);
      chk_stall = 1'b1;
      first_reg = 5'd1;
      last_reg  = 5'd4;
      start     = 1'b1;
      got       = 1'b0;
      for (int c = 0; c < 60; c++) begin
         out_ready = pat[c % 4] != 0;
         step();
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check("bp_done_seen", 64'(got), 64'(1));
      check("bp_sb_empty",  64'(sb.size()), 64'(0));
      chk_stall = 1'b0;
      out_ready = 1'b1;
      step();

      // Wrap range 30..1, register 0 reads as zero.
      rf[30] = 32'hB30; rf[31] = 32'hB31; rf[0] = 32'hDEAD; rf[1] = 32'hB01;
      push_range(5'd30, 5'd1);
      issue_start(5'd30, 5'd1);
      wait_done(20, cyc);
      check("wrap_cycles",  64'(cyc), 64'(5));
      check("wrap_sb_empty", 64'(sb.size()), 64'(0));

      // Single-register range 5..5.
      rf[5] = 32'h55;
      push_range(5'd5, 5'd5);
      issue_start(5'd5, 5'd5);
      step();
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_last",  64'(out_last), 64'(1));
      check("single_index", 64'(out_index), 64'(5));
      step();
      check("single_done",  64'(done), 64'(1));
      check("single_sb_empty", 64'(sb.size()), 64'(0));

      // Full range 0..31, r[i] = i*3.
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
      push_range(5'd0, 5'd31);
      issue_start(5'd0, 5'd31);
      wait_done(100, cyc);
      check("full_cycles",   64'(cyc), 64'(33));
      check("full_sb_empty", 64'(sb.size()), 64'(0));

      // start while busy is ignored.
      push_range(5'd0, 5'd3);
      issue_start(5'd0, 5'd3);
      step();
      first_reg = 5'd10;
      last_reg  = 5'd12;
      start     = 1'b1;
      step();
      start     = 1'b0;
      wait_done(20, cyc);
      check("busy_start_cycles",   64'(cyc), 64'(3));
      check("busy_start_sb_empty", 64'(sb.size()), 64'(0));
      step();
      check("busy_start_no_rescan", 64'(busy), 64'(0));

      // Abort while a word is valid and ready is high.
      push_range(5'd20, 5'd25);
      issue_start(5'd20, 5'd25);
      step();
      step();
      check("abort_pre_valid", 64'(out_valid), 64'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_valid", 64'(out_valid), 64'(0));
      check("abort_last",  64'(out_last), 64'(0));
      check("abort_busy",  64'(busy), 64'(0));
      check("abort_done",  64'(done), 64'(0));
      step();
      check("abort_no_done_later", 64'(done), 64'(0));
      sb.delete();

      // Abort in DRAIN beats the final handshake.
      push_range(5'd7, 5'd7);
      issue_start(5'd7, 5'd7);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_drain_done",  64'(done), 64'(0));
      check("abort_drain_busy",  64'(busy), 64'(0));
      check("abort_drain_valid", 64'(out_valid), 64'(0));
      step();
      check("abort_drain_no_done_later", 64'(done), 64'(0));
      sb.delete();

      // Auto-rescan with AUTO_PERIOD = 4.
      rf[27] = 32'h11; rf[28] = 32'h22; rf[29] = 32'h33;
      rf[2]  = 32'hC2; rf[3]  = 32'hC3;
      a_first_reg = 5'd27;
      a_last_reg  = 5'd29;
      a_start     = 1'b1;
      step();
      a_start     = 1'b0;
      a_expect_scan(5'd27, 5'd29);
      for (int r = 0; r < 2; r++) begin
         a_idle_check();
         a_expect_scan(5'd27, 5'd29);
      end
      // New bounds on the trigger cycle take precedence.
      for (int i = 0; i < 4; i++) begin
         step();
         check("auto_idle_before_trigger", 64'(a_busy), 64'(0));
      end
      a_first_reg = 5'd2;
      a_last_reg  = 5'd3;
      a_start     = 1'b1;
      step();
      a_start     = 1'b0;
      check("auto_trigger_busy", 64'(a_busy), 64'(1));
      a_expect_scan(5'd2, 5'd3);
      a_idle_check();
      a_expect_scan(5'd2, 5'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
